// File: rtl/hsrx_pkg.sv
// hsrx_pkg: shared state encoding and constants for the HS receive path
package hsrx_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ZERO_HUNT = 2'd1,
    SYNC_HUNT = 2'd2,
    LOCKED    = 2'd3
  } state_t;
  localparam logic [7:0] HS_SYNC_BYTE = 8'hB8;
  localparam int BITS_PER_CLK = 2;
endpackage

// File: rtl/hsrx_sync_matcher.sv
// hsrx_sync_matcher: compares both bit-alignment windows against the sync byte
module hsrx_sync_matcher (
  input  logic [15:7] sr_nxt,
  input  logic [7:0]  sync_word,
  output logic        match0,
  output logic        match1
);
  assign match0 = sr_nxt[15:8] == sync_word;
  assign match1 = sr_nxt[14:7] == sync_word;
endmodule

// File: rtl/hsrx_deser_sync.sv
// hsrx_deser_sync: HS-zero/sync detection, byte-boundary lock and deserialization
module hsrx_deser_sync
  import hsrx_pkg::*;
#(
  parameter int         ZERO_BITS    = 8,
  parameter logic [7:0] SYNC_WORD    = HS_SYNC_BYTE,
  parameter logic [5:0] SYNC_TIMEOUT = 6'd40
) (
  input  logic       RxDDRClkHS,
  input  logic       RxRst,
  input  logic       deserializer_en,
  input  logic [1:0] DinPair,
  output logic       Zero_Detected,
  output logic       SyncDetected,
  output logic [7:0] RxByte_HS,
  output logic       RxByteValid,
  output logic       AlignOffset,
  output logic       ErrSotSyncHS
);
  state_t      state;
  logic [15:9] sr;
  logic [15:7] sr_nxt;
  logic [4:0]  zc;
  logic [4:0]  zc_nxt;
  logic [5:0]  zsum;
  logic [5:0]  tmo;
  logic [5:0]  tmo_nxt;
  logic [1:0]  phase;
  logic        match0;
  logic        match1;
  // only the history bits that either window can still reach are kept
  assign sr_nxt  = {DinPair[1], DinPair[0], sr[15:9]};
  assign zsum    = {1'b0, zc} + 6'd2;
  assign zc_nxt  = DinPair[1] ? 5'd0 : DinPair[0] ? 5'd1 : zsum[5] ? 5'd31 : zsum[4:0];
  assign tmo_nxt = tmo + 6'd1;
  hsrx_sync_matcher u_match (
    .sr_nxt   (sr_nxt),
    .sync_word(SYNC_WORD),
    .match0   (match0),
    .match1   (match1)
  );
  always_ff @(posedge RxDDRClkHS) begin
    if (RxRst) begin
      state         <= IDLE;
      sr            <= '0;
      zc            <= '0;
      tmo           <= '0;
      phase         <= '0;
      Zero_Detected <= 1'b0;
      SyncDetected  <= 1'b0;
      RxByte_HS     <= 8'h00;
      RxByteValid   <= 1'b0;
      AlignOffset   <= 1'b0;
      ErrSotSyncHS  <= 1'b0;
    end else if (!deserializer_en) begin
      state         <= IDLE;
      sr            <= '0;
      zc            <= '0;
      tmo           <= '0;
      phase         <= '0;
      Zero_Detected <= 1'b0;
      SyncDetected  <= 1'b0;
      RxByteValid   <= 1'b0;
      AlignOffset   <= 1'b0;
      ErrSotSyncHS  <= 1'b0;
    end else begin
      sr           <= sr_nxt[15:9];
      zc           <= zc_nxt;
      SyncDetected <= 1'b0;
      RxByteValid  <= 1'b0;
      ErrSotSyncHS <= 1'b0;
      case (state)
        IDLE: state <= ZERO_HUNT;
        ZERO_HUNT:
          if (zc_nxt >= 5'(ZERO_BITS)) begin
            state         <= SYNC_HUNT;
            Zero_Detected <= 1'b1;
            tmo           <= '0;
          end
        SYNC_HUNT: begin
          tmo <= tmo_nxt;
          if (match0 || match1) begin
            state         <= LOCKED;
            AlignOffset   <= !match0;
            SyncDetected  <= 1'b1;
            Zero_Detected <= 1'b0;
            phase         <= '0;
          end else if (tmo_nxt == SYNC_TIMEOUT) begin
            state         <= ZERO_HUNT;
            ErrSotSyncHS  <= 1'b1;
            Zero_Detected <= 1'b0;
            zc            <= '0;
            tmo           <= '0;
          end
        end
        LOCKED: begin
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            RxByte_HS   <= AlignOffset ? sr_nxt[14:7] : sr_nxt[15:8];
            RxByteValid <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
